// File: rtl/mycpu_pkg.sv
// Shared types and constants for the memory-mapped I/O port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mycpu_pkg;

  // Register select on addr_in
  typedef enum logic [1:0] {
    IO_DATA = 2'd0,
    IO_STAT = 2'd1,
    IO_CTRL = 2'd2,
    IO_RSVD = 2'd3
  } io_addr_t;

  // Bit positions inside the STATUS word
  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXFULL  = 2;
  localparam int ST_OVF     = 3;

  // One-entry RX holding register occupancy
  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } io_rx_state_t;

endpackage

// File: rtl/io_port_if.sv
// Bundle of CPU access, TX stream, RX stream and interrupt signals of io_port.
// Latency: n/a (wires only).
// Backpressure: tx_ready_in / rx_ready_out carry the valid/ready handshakes.
// Ports: slave = the io_port side, master = the CU/device side driving it.
interface io_port_if #(
  parameter int DATA_W = 16
);
  // CPU side
  logic              iom_in;
  logic              wen_in;
  logic [1:0]        addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] rdata_out;
  // TX stream towards the device
  logic [DATA_W-1:0] tx_data_out;
  logic              tx_valid_out;
  logic              tx_ready_in;
  // RX stream from the device
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_valid_in;
  logic              rx_ready_out;
  // Interrupt
  logic              irq_out;

  modport slave (
    input  iom_in, wen_in, addr_in, wdata_in, tx_ready_in, rx_data_in, rx_valid_in,
    output rdata_out, tx_data_out, tx_valid_out, rx_ready_out, irq_out
  );

  modport master (
    output iom_in, wen_in, addr_in, wdata_in, tx_ready_in, rx_data_in, rx_valid_in,
    input  rdata_out, tx_data_out, tx_valid_out, rx_ready_out, irq_out
  );
endinterface

// File: rtl/io_fifo.sv
// Generic synchronous FIFO holding the TX words; dout shows the head entry.
// Latency: a push is visible on dout the cycle after the edge that wrote it.
// Backpressure: push is ignored when full, pop is ignored when empty.
// Ports: clk, rst_n, push/din (write side), pop/dout (read side), full, empty.
module io_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4   // power of two, >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come from the registered count, so a push into a full FIFO is
  // dropped even if a pop frees a slot at the same edge.
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;   // wraps naturally at DEPTH
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/io_port.sv
// Memory-mapped I/O responder: CPU DATA writes feed a TX FIFO, CPU DATA reads pop a one-entry RX register.
// Latency: CPU reads are combinational; TX word on tx_data_out one cycle after write into empty FIFO; RX word readable one cycle after capture.
// Backpressure: TX writes to a full FIFO are dropped and flag ovf; rx_ready_out is low while the RX register holds an unread word.
// Ports: clk, rst_n (async active-low), bus (io_port_if.slave: CPU iom/wen/addr/wdata/rdata, TX and RX valid/ready streams, irq).
// Build option: define IO_IRQ_EN to add the CTRL register at address 2 and a registered irq_out; otherwise irq_out is 0.
module io_port
  import mycpu_pkg::*;
#(
  parameter int DATA_W   = 16,   // >= 4 so the STATUS bits fit
  parameter int TX_DEPTH = 4     // power of two, >= 2
) (
  input  logic      clk,
  input  logic      rst_n,
  io_port_if.slave  bus
);
  io_addr_t          addr;
  logic              wr;
  logic              rd;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic              ovf;
  io_rx_state_t      rx_state;
  io_rx_state_t      rx_next;
  logic              rx_capture;
  logic              rx_full;
  logic [DATA_W-1:0] rx_data_r;

  // ---------------- access decode ----------------
  assign addr = io_addr_t'(bus.addr_in);
  assign wr   = bus.iom_in & ~bus.wen_in;
  assign rd   = bus.iom_in &  bus.wen_in;

  // ---------------- TX path ----------------
  assign tx_push          = wr & (addr == IO_DATA);
  assign tx_pop           = bus.tx_valid_out & bus.tx_ready_in;
  assign bus.tx_valid_out = ~tx_empty;

  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.wdata_in),
    .dout  (bus.tx_data_out),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Sticky overflow: set by a dropped DATA write, cleared by writing 1 to
  // bit 3 of STATUS. Both cannot happen in one cycle (different addresses).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (tx_push && tx_full) begin
      ovf <= 1'b1;
    end else if (wr && (addr == IO_STAT) && bus.wdata_in[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  // ---------------- RX holding register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_EMPTY;
      rx_data_r <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_capture) rx_data_r <= bus.rx_data_in;
    end
  end

  // Capture only happens in EMPTY and a pop only in FULL, so they never collide.
  always_comb begin
    rx_next    = rx_state;
    rx_capture = 1'b0;
    case (rx_state)
      RX_EMPTY: begin
        if (bus.rx_valid_in) begin
          rx_next    = RX_FULL;
          rx_capture = 1'b1;
        end
      end
      RX_FULL: begin
        if (rd && (addr == IO_DATA)) rx_next = RX_EMPTY;
      end
      default: rx_next = RX_EMPTY;
    endcase
  end

  assign rx_full          = (rx_state == RX_FULL);
  assign bus.rx_ready_out = (rx_state == RX_EMPTY);

  // ---------------- optional CTRL / IRQ ----------------
`ifdef IO_IRQ_EN
  logic [1:0] ctrl;
  logic       irq_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl  <= 2'b00;
      irq_r <= 1'b0;
    end else begin
      if (wr && (addr == IO_CTRL)) ctrl <= bus.wdata_in[1:0];
      irq_r <= (ctrl[0] & rx_full) | (ctrl[1] & tx_empty);
    end
  end

  assign bus.irq_out = irq_r;
`else
  assign bus.irq_out = 1'b0;
`endif

  // ---------------- CPU read mux ----------------
  always_comb begin
    bus.rdata_out = '0;
    if (rd) begin
      case (addr)
        IO_DATA: if (rx_full) bus.rdata_out = rx_data_r;
        IO_STAT: begin
          bus.rdata_out[ST_TXFULL]  = tx_full;
          bus.rdata_out[ST_TXEMPTY] = tx_empty;
          bus.rdata_out[ST_RXFULL]  = rx_full;
          bus.rdata_out[ST_OVF]     = ovf;
        end
`ifdef IO_IRQ_EN
        IO_CTRL: bus.rdata_out[1:0] = ctrl;
`endif
        default: bus.rdata_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port with TX/RX scoreboard queues.
// Latency: n/a (testbench).
// Backpressure: tx_ready_in and rx_valid_in are driven directly by the steps below.
module tb_io_port;
  import mycpu_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_port_if #(.DATA_W(DW)) bus ();

  io_port #(.DATA_W(DW), .TX_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.iom_in   = 1'b0;
    bus.wen_in   = 1'b1;
    bus.addr_in  = 2'd0;
    bus.wdata_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [1:0] a, input logic [DW-1:0] d);
    bus.iom_in   = 1'b1;
    bus.wen_in   = 1'b0;
    bus.addr_in  = a;
    bus.wdata_in = d;
    step();
    idle();
  endtask

  // DATA write with scoreboard: the word is expected only if the FIFO had room.
  task automatic wr_data(input logic [DW-1:0] d);
    if (txq.size() < DEPTH) txq.push_back(d);
    io_wr(IO_DATA, d);
  endtask

  task automatic io_rd(input logic [1:0] a, output logic [DW-1:0] d);
    bus.iom_in  = 1'b1;
    bus.wen_in  = 1'b1;
    bus.addr_in = a;
    #1;
    d = bus.rdata_out;
    step();
    idle();
  endtask

  task automatic chk_stat(input string tag, input logic [DW-1:0] exp);
    logic [DW-1:0] s;
    io_rd(IO_STAT, s);
    check(tag, s, exp);
  endtask

  // Drain n cycles with tx_ready_in=1, comparing each head word against the queue.
  task automatic drain(input int n);
    bus.tx_ready_in = 1'b1;
    repeat (n) begin
      #1;
      if (txq.size() > 0) begin
        check("tx_valid_drain", bus.tx_valid_out, 1);
        check("tx_data_drain", bus.tx_data_out, txq.pop_front());
      end else begin
        check("tx_valid_idle", bus.tx_valid_out, 0);
      end
      step();
    end
    bus.tx_ready_in = 1'b0;
  endtask

  initial begin
    idle();
    bus.tx_ready_in = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in  = '0;

    // ---------------- reset state ----------------
    #12;
    check("rst_tx_valid", bus.tx_valid_out, 0);
    check("rst_tx_data", bus.tx_data_out, 0);
    check("rst_rx_ready", bus.rx_ready_out, 1);
    check("rst_irq", bus.irq_out, 0);
    check("rst_rdata", bus.rdata_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk_stat("rst_status", 16'h0002);

    // ---------------- two writes, then drain ----------------
    wr_data(16'hA5A5);
    wr_data(16'h1234);
    #1;
    check("tx_valid_after_wr", bus.tx_valid_out, 1);
    check("tx_head_after_wr", bus.tx_data_out, 16'hA5A5);
    drain(2);
    chk_stat("status_drained", 16'h0002);

    // ---------------- overflow ----------------
    for (int i = 1; i <= 5; i++) wr_data(DW'(i));
    chk_stat("status_ovf_full", 16'h0009);
    io_wr(IO_STAT, 16'hFFF7);           // bit 3 clear: ovf must stay
    chk_stat("status_ovf_kept", 16'h0009);
    io_wr(IO_STAT, 16'h0008);
    chk_stat("status_ovf_clr", 16'h0001);
    drain(5);                            // 1..4 then idle
    chk_stat("status_after_ovf_drain", 16'h0002);

    // ---------------- write to full FIFO while popping ----------------
    for (int i = 0; i < DEPTH; i++) wr_data(DW'(16'h0010 + i));
    chk_stat("status_full", 16'h0001);
    bus.tx_ready_in = 1'b1;
    bus.iom_in      = 1'b1;
    bus.wen_in      = 1'b0;
    bus.addr_in     = IO_DATA;
    bus.wdata_in    = 16'h00FF;
    if (txq.size() < DEPTH) txq.push_back(16'h00FF);
    #1;
    check("tx_head_pop_wr", bus.tx_data_out, txq.pop_front());
    step();
    idle();
    bus.tx_ready_in = 1'b0;
    chk_stat("status_pop_wr", 16'h0008);  // count 3: not full, not empty, ovf
    drain(4);
    io_wr(IO_STAT, 16'h0008);
    chk_stat("status_clean", 16'h0002);

    // ---------------- RX capture held 3 cycles ----------------
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 16'hBEEF;
    rxq.push_back(16'hBEEF);
    #1;
    check("rx_ready_before", bus.rx_ready_out, 1);
    repeat (3) step();
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in  = '0;
    check("rx_ready_full", bus.rx_ready_out, 0);
    check("rdata_no_iom", bus.rdata_out, 0);
    chk_stat("status_rx_full", 16'h0006);
    io_rd(IO_DATA, r);
    check("rx_read", r, rxq.pop_front());
    check("rx_ready_after_pop", bus.rx_ready_out, 1);
    io_rd(IO_DATA, r);
    check("rx_read_empty", r, 0);
    io_rd(IO_RSVD, r);
    check("rsvd_read", r, 0);

    // ---------------- CTRL / IRQ ----------------
`ifdef IO_IRQ_EN
    io_wr(IO_CTRL, 16'h0001);
    io_rd(IO_CTRL, r);
    check("ctrl_read", r, 16'h0001);
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 16'hC0DE;
    rxq.push_back(16'hC0DE);
    step();                              // capture edge
    bus.rx_valid_in = 1'b0;
    check("irq_at_capture", bus.irq_out, 0);
    step();
    check("irq_after_capture", bus.irq_out, 1);
    io_rd(IO_DATA, r);                   // pop edge
    check("irq_rx_read", r, rxq.pop_front());
    check("irq_at_pop", bus.irq_out, 1);
    step();
    check("irq_after_pop", bus.irq_out, 0);
    io_wr(IO_CTRL, 16'h0002);
    check("irq_txe_delay", bus.irq_out, 0);
    step();
    check("irq_txe", bus.irq_out, 1);
    io_wr(IO_CTRL, 16'h0001);
    step();
    check("irq_off", bus.irq_out, 0);
`else
    io_wr(IO_CTRL, 16'h0003);
    io_rd(IO_CTRL, r);
    check("ctrl_absent", r, 0);
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 16'hC0DE;
    rxq.push_back(16'hC0DE);
    step();
    bus.rx_valid_in = 1'b0;
    step();
    check("irq_tied", bus.irq_out, 0);
    io_rd(IO_DATA, r);
    check("rx_read2", r, rxq.pop_front());
`endif

    // ---------------- reset mid-operation ----------------
    wr_data(16'h1111);
    wr_data(16'h2222);
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 16'h3333;
    step();
    bus.rx_valid_in = 1'b0;
    bus.tx_ready_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    txq.delete();
    rxq.delete();
    check("mid_rst_tx_valid", bus.tx_valid_out, 0);
    check("mid_rst_tx_data", bus.tx_data_out, 0);
    check("mid_rst_rx_ready", bus.rx_ready_out, 1);
    check("mid_rst_irq", bus.irq_out, 0);
    check("mid_rst_rdata", bus.rdata_out, 0);
    bus.tx_ready_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // first edge after release already accepts a write
    wr_data(16'h4444);
    #1;
    check("post_rst_tx_valid", bus.tx_valid_out, 1);
    check("post_rst_irq", bus.irq_out, 0);
    drain(2);
    chk_stat("post_rst_status", 16'h0002);
    io_rd(IO_DATA, r);
    check("post_rst_rx_empty", r, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard stop in case something blocks the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of sequence, expected completion");
    $fatal(1, "timeout");
  end
endmodule
